alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-and-issue pipeline stage that sits directly upstream of the 32-bit ALU. It accepts decoded instruction fields and register operands over a valid/ready handshake, translates the main-decoder ALUOp and funct fields into the ALU's 4-bit op code, selects and extends the B operand, and presents registered a/b/op to the ALU. A 2-entry elastic buffer (output register plus skid register) keeps full throughput under downstream back-pressure.

## Interface
- No parameters. Datapath width is fixed at 32 bits and the ALU op code at 4 bits.
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Reset; synchronous, active-high.
- flush  in  1  Synchronous pipeline flush; drops all held entries.
- in_valid  in  1  Upstream entry valid.
- in_ready  out  1  Stage can accept an entry. Registered.
- in_aluop  in  2  Main-decoder ALU class.
- in_funct  in  6  R-type funct field.
- in_alusrc  in  1  1 = B operand is the extended immediate; 0 = in_rt.
- in_rs  in  32  Register operand A.
- in_rt  in  32  Register operand B.
- in_imm  in  16  Instruction immediate.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  Downstream accepts the entry this cycle.
- out_a  out  32  ALU operand a.
- out_b  out  32  ALU operand b.
- out_op  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- out_illegal  out  1  The entry had an undecodable funct.

## Operation
- Decode is combinational on the input side and is captured with the entry:
  - in_aluop 00: ADD (load/store address).
  - in_aluop 01: SUB (branch compare).
  - in_aluop 10: use in_funct. 100000 gives ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct gives op 0010 with illegal=1.
  - in_aluop 11: OR with a zero-extended immediate (ori). in_alusrc is ignored and treated as 1.
- Immediate extension:
  - Zero-extend for aluop 11.
  - Otherwise sign-extend: {{16{imm[15]}}, imm}.
- out_a = in_rs. out_b = extended immediate if the immediate is selected, else in_rt.
- Storage consists of an output register (OR) and a skid register (SK), each holding {a, b, op, illegal} plus a valid bit.
- Accept occurs when in_valid && in_ready. Drain occurs when out_valid && out_ready.
- Next-state rules, in priority order:
  - rst: OR and SK are both invalid. All data fields are 0.
  - flush: OR and SK are both invalid. Any accept in the same cycle is discarded. Data fields keep their values.
  - OR empty, or drain this cycle:
    - If SK is valid, SK moves into OR, SK becomes invalid, and an accept this cycle is impossible.
    - Otherwise an accept loads OR directly.
  - OR full and no drain: an accept loads SK.
- in_ready = !SK.valid, registered from next state. An entry is never overwritten or dropped except by flush or rst.
- out_* is driven directly from OR. Data fields are undefined-but-stable while out_valid=0; the implementation holds the last values.

## Timing
- Reset values:
  - in_ready=0 while rst is high, and 1 on the first cycle after rst deasserts.
  - out_valid=0, out_a=0, out_b=0, out_op=0000, out_illegal=0.
- Latency: an entry accepted at edge N is on out_* with out_valid=1 after edge N. The ALU result is therefore available combinationally in cycle N+1.
- Throughput is 1 entry/cycle with out_ready held high. SK stays empty and in_ready stays 1.
- Stall: if out_ready drops with OR full, one more entry can be accepted into SK, and in_ready falls after that edge.
- Release: the first drain moves SK into OR, and in_ready rises after that edge. There is no bubble on the output.
- Simultaneous accept and drain with SK empty: the new entry replaces OR at the same edge, and out_valid stays 1.
- Flush together with in_valid and in_ready: the entry is dropped. After the edge, out_valid=0 and in_ready=1.
- Reset mid-stall: both entries are discarded and the reset values apply after the edge.
- Output ordering is strictly FIFO.

## Test plan
- Decode sweep, with out_ready=1 and aluop=10:
  - funct 100000, 100010, 100100, 100101 and 101010 give op 0010, 0110, 0000, 0001 and 0111 one cycle later, with illegal=0.
  - funct 000000 gives op 0010 with illegal=1.
- Immediate extension:
  - aluop=00, alusrc=1, imm=16'hFFFC gives out_b=32'hFFFFFFFC and op 0010.
  - aluop=11, imm=16'h8001 gives out_b=32'h00008001 and op 0001.
  - aluop=01, alusrc=0, rt=32'h5 gives out_b=5 and op 0110.
- Back-pressure: stream entries 1..6 on consecutive cycles and hold out_ready=0 for cycles 2–4.
  - in_ready falls after the second entry is held.
  - Entries emerge in order 1..6 with none lost or duplicated.
  - in_ready returns 1 the cycle after the first drain.
- Simultaneous accept and drain at steady state: out_valid stays 1 every cycle and out_a follows in_rs with exactly 1-cycle latency.
- Flush with both OR and SK full plus in_valid=1:
  - Next cycle out_valid=0 and in_ready=1.
  - The dropped entries never appear.
- Reset during a stall with both registers full: next cycle out_valid=0, out_op=0000 and in_ready=0. in_ready=1 on the first cycle after rst deasserts.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 32-bit ALU: decodes ALUOp/funct, builds operand B,
// and buffers entries in an output register plus a skid register.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_aluop,
    input  logic [5:0]  in_funct,
    input  logic        in_alusrc,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_op,
    output logic        out_illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    // Returns {op, illegal}; unknown R-type funct falls back to ADD and flags illegal.
    function automatic logic [4:0] decode_op(input logic [1:0] aluop, input logic [5:0] funct);
        logic [4:0] res;
        case (aluop)
            2'b00: res = {OP_ADD, 1'b0};
            2'b01: res = {OP_SUB, 1'b0};
            2'b11: res = {OP_OR, 1'b0};
            2'b10: begin
                case (funct)
                    6'b100000: res = {OP_ADD, 1'b0};
                    6'b100010: res = {OP_SUB, 1'b0};
                    6'b100100: res = {OP_AND, 1'b0};
                    6'b100101: res = {OP_OR, 1'b0};
                    6'b101010: res = {OP_SLT, 1'b0};
                    default:   res = {OP_ADD, 1'b1};
                endcase
            end
            default: res = {OP_ADD, 1'b1};
        endcase
        return res;
    endfunction

    // Entry layout: {a[31:0], b[31:0], op[3:0], illegal}
    logic [68:0] in_entry_s;
    logic [68:0] or_data_r;
    logic [68:0] sk_data_r;
    logic        or_valid_r;
    logic        sk_valid_r;
    logic        in_ready_r;

    logic [4:0]  dec_s;
    logic [31:0] in_b_s;
    logic        accept_s;
    logic        drain_s;
    logic        or_valid_n_s;
    logic        sk_valid_n_s;
    logic        or_from_in_s;
    logic        or_from_sk_s;
    logic        sk_from_in_s;

    // Input-side decode and B operand selection.
    always_comb begin
        dec_s = decode_op(in_aluop, in_funct);
        if (in_aluop == 2'b11) begin
            in_b_s = {16'h0000, in_imm};
        end else if (in_alusrc) begin
            in_b_s = {{16{in_imm[15]}}, in_imm};
        end else begin
            in_b_s = in_rt;
        end
        in_entry_s = {in_rs, in_b_s, dec_s};
    end

    // Next-state control for the output/skid pair.
    always_comb begin
        accept_s     = in_valid && in_ready_r;
        drain_s      = or_valid_r && out_ready;
        or_valid_n_s = or_valid_r;
        sk_valid_n_s = sk_valid_r;
        or_from_in_s = 1'b0;
        or_from_sk_s = 1'b0;
        sk_from_in_s = 1'b0;
        if (flush) begin
            or_valid_n_s = 1'b0;
            sk_valid_n_s = 1'b0;
        end else if (!or_valid_r || drain_s) begin
            // in_ready is low whenever SK is full, so no accept competes with the SK move.
            if (sk_valid_r) begin
                or_from_sk_s = 1'b1;
                or_valid_n_s = 1'b1;
                sk_valid_n_s = 1'b0;
            end else if (accept_s) begin
                or_from_in_s = 1'b1;
                or_valid_n_s = 1'b1;
            end else begin
                or_valid_n_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                sk_from_in_s = 1'b1;
                sk_valid_n_s = 1'b1;
            end else begin
                sk_valid_n_s = sk_valid_r;
            end
        end
    end

    // Storage update; data fields only clear on reset and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid_r <= 1'b0;
            sk_valid_r <= 1'b0;
            in_ready_r <= 1'b0;
            or_data_r  <= 69'd0;
            sk_data_r  <= 69'd0;
        end else begin
            or_valid_r <= or_valid_n_s;
            sk_valid_r <= sk_valid_n_s;
            in_ready_r <= !sk_valid_n_s;
            if (or_from_sk_s) begin
                or_data_r <= sk_data_r;
            end else if (or_from_in_s) begin
                or_data_r <= in_entry_s;
            end
            if (sk_from_in_s) begin
                sk_data_r <= in_entry_s;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = or_valid_r;
    assign out_a       = or_data_r[68:37];
    assign out_b       = or_data_r[36:5];
    assign out_op      = or_data_r[4:1];
    assign out_illegal = or_data_r[0];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised and directed bench for alu_issue_stage against a 2-deep FIFO reference model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_alusrc;
    logic        out_valid, out_ready, out_illegal;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [31:0] in_rs, in_rt, out_a, out_b;
    logic [15:0] in_imm;
    logic [3:0]  out_op;

    int n_checks = 0;
    int n_fail   = 0;

    logic [68:0] m_q[$];
    logic [68:0] m_last = 69'd0;
    logic        m_ready = 1'b0;
    logic [31:0] dut_drained[$];

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_funct(in_funct), .in_alusrc(in_alusrc),
        .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_illegal(out_illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference entry straight from the decode table: {a, b, op, illegal}.
    function automatic logic [68:0] ref_entry(input logic [1:0] aluop, input logic [5:0] funct,
                                              input logic alusrc, input logic [31:0] rs,
                                              input logic [31:0] rt, input logic [15:0] imm);
        logic [3:0]  op;
        logic        ill;
        logic [31:0] b;
        ill = 1'b0;
        case (aluop)
            2'd0: op = 4'd2;
            2'd1: op = 4'd6;
            2'd3: op = 4'd1;
            default: begin
                case (funct)
                    6'd32:   op = 4'd2;
                    6'd34:   op = 4'd6;
                    6'd36:   op = 4'd0;
                    6'd37:   op = 4'd1;
                    6'd42:   op = 4'd7;
                    default: begin op = 4'd2; ill = 1'b1; end
                endcase
            end
        endcase
        if (aluop == 2'd3)  b = {16'd0, imm};
        else if (alusrc)    b = {{16{imm[15]}}, imm};
        else                b = rt;
        return {rs, b, op, ill};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_q.delete();
            m_last  = 69'd0;
            m_ready = 1'b0;
        end else if (flush) begin
            if (m_q.size() > 0) m_last = m_q[0];
            m_q.delete();
            m_ready = 1'b1;
        end else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (in_valid && m_ready)
                m_q.push_back(ref_entry(in_aluop, in_funct, in_alusrc, in_rs, in_rt, in_imm));
            if (m_q.size() > 0) m_last = m_q[0];
            m_ready = (m_q.size() < 2);
        end
    endtask

    task automatic cycle();
        logic [68:0] e;
        if (out_valid === 1'b1 && out_ready) dut_drained.push_back(out_a);
        @(posedge clk);
        model_step();
        #1;
        e = (m_q.size() > 0) ? m_q[0] : m_last;
        check_eq("in_ready",    32'(in_ready),    32'(m_ready));
        check_eq("out_valid",   32'(out_valid),   32'(m_q.size() > 0));
        check_eq("out_a",       out_a,            e[68:37]);
        check_eq("out_b",       out_b,            e[36:5]);
        check_eq("out_op",      32'(out_op),      32'(e[4:1]));
        check_eq("out_illegal", 32'(out_illegal), 32'(e[0]));
    endtask

    task automatic drive(input logic v, input logic [1:0] aluop, input logic [5:0] funct,
                         input logic s, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm);
        in_valid  = v;
        in_aluop  = aluop;
        in_funct  = funct;
        in_alusrc = s;
        in_rs     = rs;
        in_rt     = rt;
        in_imm    = imm;
    endtask

    task automatic drive_rand(input logic v);
        logic [5:0] fl[6];
        fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        drive(v, 2'($urandom_range(0, 3)), fl[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
              $urandom, $urandom, 16'($urandom));
    endtask

    logic [5:0] sweep_funct[6];
    logic [3:0] sweep_op[6];
    int k;
    logic acc;

    initial begin
        sweep_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        sweep_op    = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0010};
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 2'd0, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
        cycle();
        cycle();
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_op",   32'(out_op),   32'd0);
        rst = 1'b0;
        cycle();
        check_eq("post_rst_ready", 32'(in_ready), 32'd1);

        // Decode sweep
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'b10, sweep_funct[i], 1'b0, 32'(i + 100), 32'(i), 16'd0);
            cycle();
            check_eq("sweep_op",  32'(out_op),      32'(sweep_op[i]));
            check_eq("sweep_ill", 32'(out_illegal), (i == 5) ? 32'd1 : 32'd0);
        end

        // Immediate extension
        drive(1'b1, 2'b00, 6'd0, 1'b1, 32'd7, 32'd9, 16'hFFFC);
        cycle();
        check_eq("sext_b", out_b, 32'hFFFFFFFC);
        drive(1'b1, 2'b11, 6'd0, 1'b0, 32'd7, 32'd9, 16'h8001);
        cycle();
        check_eq("zext_b",  out_b, 32'h00008001);
        check_eq("zext_op", 32'(out_op), 32'd1);
        drive(1'b1, 2'b01, 6'd0, 1'b0, 32'd7, 32'h5, 16'hFFFF);
        cycle();
        check_eq("rt_b",  out_b, 32'd5);
        check_eq("rt_op", 32'(out_op), 32'd6);
        drive(1'b0, 2'd0, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
        cycle();

        // Back-pressure: entries 1..6, out_ready low for cycles 2-4
        dut_drained.delete();
        k = 1;
        for (int c = 1; c <= 16; c++) begin
            drive(k <= 6, 2'b10, 6'd32, 1'b0, 32'(k), 32'd0, 16'd0);
            out_ready = !(c >= 2 && c <= 4);
            acc = in_valid && in_ready;
            cycle();
            if (c == 2) check_eq("bp_ready_fall", 32'(in_ready), 32'd0);
            if (c == 5) check_eq("bp_ready_rise", 32'(in_ready), 32'd1);
            if (acc) k++;
        end
        check_eq("bp_count", 32'(dut_drained.size()), 32'd6);
        for (int i = 0; i < 6 && i < dut_drained.size(); i++)
            check_eq("bp_order", dut_drained[i], 32'(i + 1));

        // Steady state simultaneous accept/drain
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_rand(1'b1);
            cycle();
            check_eq("steady_valid", 32'(out_valid), 32'd1);
            check_eq("steady_a", out_a, in_rs);
        end

        // Flush with OR and SK full plus in_valid
        out_ready = 1'b0;
        drive_rand(1'b1); cycle();
        drive_rand(1'b1); cycle();
        flush = 1'b1;
        drive_rand(1'b1);
        cycle();
        check_eq("flush_valid", 32'(out_valid), 32'd0);
        check_eq("flush_ready", 32'(in_ready),  32'd1);
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 2'd0, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("flush_no_ghost", 32'(out_valid), 32'd0);
        end

        // Reset during stall
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 6'd0, 1'b0, 32'd11, 32'd3, 16'd0); cycle();
        drive(1'b1, 2'b10, 6'd42, 1'b0, 32'd12, 32'd4, 16'd0); cycle();
        rst = 1'b1;
        cycle();
        check_eq("rst_stall_valid", 32'(out_valid), 32'd0);
        check_eq("rst_stall_op",    32'(out_op),    32'd0);
        check_eq("rst_stall_ready", 32'(in_ready),  32'd0);
        rst = 1'b0;
        drive(1'b0, 2'd0, 6'd0, 1'b0, 32'd0, 32'd0, 16'd0);
        cycle();
        check_eq("rst_release_ready", 32'(in_ready), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 59) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
